lsu_wb_stage: RTL and testbench

- Load/store unit sitting between execute and the 32x32 register file.
- Accepts one memory request at a time from execute and runs a req/ack handshake with data memory.
- Aligns load data and drives the register file write port: address, data and the 3-bit write-enable code.
- Sign/zero extension stays in the register file; this block only selects and right-justifies bytes.

---
 rtl/lsu_wb_stage.sv | 150 +++++++++++++++
 tb/tb_lsu_wb_stage.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_wb_stage.sv
// Load/store writeback stage: one outstanding request, req/ack data-memory handshake, load alignment for the register file.
// Optional macro LSU_MISALIGN_TRAP_EN rejects misaligned half/word requests with an err pulse instead of truncating.
module lsu_wb_stage #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [2:0]  wb_we,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        busy,
    output logic        err
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] WB     = 2'd2;

    logic [1:0] state;
    logic [7:0] cnt;
    logic [1:0] lat_size;
    logic       lat_uns;
    logic [1:0] lat_lo;
    logic [4:0] lat_rd;
    logic       trap;

    function automatic logic [3:0] be_of(input logic we, input logic [1:0] size, input logic [1:0] lo);
        if (!we) return 4'b1111;
        case (size)
            2'b00:   return 4'b0001 << lo;
            2'b01:   return lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] wdata_of(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            2'b00:   return {4{wdata[7:0]}};
            2'b01:   return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    function automatic logic [31:0] align(input logic [1:0] size, input logic [1:0] lo, input logic [31:0] rdata);
        case (size)
            2'b00:   return rdata >> {lo, 3'b000};
            2'b01:   return rdata >> {lo[1], 4'b0000};
            default: return rdata;
        endcase
    endfunction

    // Sign/zero extension happens in the register file; we only tell it which flavour.
    function automatic logic [2:0] wb_code(input logic [1:0] size, input logic uns, input logic [4:0] rd);
        if (rd == 5'd0) return 3'b000;
        case (size)
            2'b00:   return uns ? 3'b100 : 3'b010;
            2'b01:   return uns ? 3'b101 : 3'b011;
            default: return 3'b001;
        endcase
    endfunction

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = (req_size == 2'b01 && req_addr[0]) || (req_size[1] && req_addr[1:0] != 2'b00);
`else
    assign trap = 1'b0;
`endif

    // Combinational so an asynchronous reset drops them immediately.
    assign mem_req   = (state == ACCESS);
    assign busy      = (state != IDLE);
    assign req_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            lat_size  <= 2'b00;
            lat_uns   <= 1'b0;
            lat_lo    <= 2'b00;
            lat_rd    <= 5'd0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_be    <= 4'b0000;
            wb_we     <= 3'b000;
            wb_addr   <= 5'd0;
            wb_data   <= 32'd0;
            err       <= 1'b0;
        end else begin
            err   <= 1'b0;
            wb_we <= 3'b000;
            case (state)
                IDLE: begin
                    if (req_valid && trap) begin
                        err <= 1'b1;
                    end else if (req_valid) begin
                        lat_size  <= req_size;
                        lat_uns   <= req_unsigned;
                        lat_lo    <= req_addr[1:0];
                        lat_rd    <= req_rd;
                        mem_we    <= req_we;
                        mem_addr  <= {req_addr[31:2], 2'b00};
                        mem_wdata <= wdata_of(req_size, req_wdata);
                        mem_be    <= be_of(req_we, req_size, req_addr[1:0]);
                        cnt       <= 8'd0;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    // An ack in the final timeout cycle still completes the access.
                    if (mem_ack) begin
                        cnt <= 8'd0;
                        if (mem_we) begin
                            state <= IDLE;
                        end else begin
                            state   <= WB;
                            wb_we   <= wb_code(lat_size, lat_uns, lat_rd);
                            wb_addr <= lat_rd;
                            wb_data <= align(lat_size, lat_lo, mem_rdata);
                        end
                    end else if (cnt == 8'(TIMEOUT_CYC - 1)) begin
                        cnt   <= 8'd0;
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                WB:      state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_wb_stage.sv
// Self-checking bench for lsu_wb_stage: vector table of load/store transactions plus hand-written timeout/reset/misalign sequences.
module tb_lsu_wb_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [4:0]  req_rd = 5'd0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic [2:0]  wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        busy;
    logic        err;

    lsu_wb_stage #(.TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] rdata;
        int          dly;
        logic [31:0] e_maddr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [2:0]  e_wbwe;
        logic [31:0] e_wbdata;
    } vec_t;

    typedef struct {
        logic [2:0]  we;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    wb_t  sbq[$];
    vec_t vt[12];
    vec_t v;
    int   tests = 0;
    int   fails = 0;
    int   nreq, nerr, nwb;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Scoreboard: every writeback the DUT produces must match the oldest expected one.
    wb_t got;
    always @(negedge clk) begin
        if (rst && wb_we !== 3'b000) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL wb_unexpected actual=%b required=000", wb_we);
            end else begin
                got = sbq.pop_front();
                chk("sb_wb_we", {29'd0, wb_we}, {29'd0, got.we});
                chk("sb_wb_addr", {27'd0, wb_addr}, {27'd0, got.rd});
                chk("sb_wb_data", wb_data, got.data);
            end
        end
    end

    task automatic drive_req(input vec_t t);
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = t.we;
        req_size     = t.size;
        req_unsigned = t.uns;
        req_addr     = t.addr;
        req_wdata    = t.wdata;
        req_rd       = t.rd;
    endtask

    task automatic do_txn(input vec_t t);
        drive_req(t);
        chk("req_ready", {31'd0, req_ready}, 32'd1);
        if (!t.we && t.e_wbwe != 3'b000) sbq.push_back('{t.e_wbwe, t.rd, t.e_wbdata});
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("mem_req_start", {31'd0, mem_req}, 32'd1);
        chk("mem_we", {31'd0, mem_we}, {31'd0, t.we});
        chk("mem_addr", mem_addr, t.e_maddr);
        chk("mem_be", {28'd0, mem_be}, {28'd0, t.e_be});
        if (t.we) chk("mem_wdata", mem_wdata, t.e_wdata);
        repeat (t.dly) begin
            @(posedge clk); #1;
        end
        chk("mem_req_hold", {31'd0, mem_req}, 32'd1);
        chk("mem_addr_hold", mem_addr, t.e_maddr);
        mem_ack   = 1'b1;
        mem_rdata = t.rdata;
        @(posedge clk); #1;
        mem_ack   = 1'b0;
        mem_rdata = 32'h5A5A_5A5A;
        if (t.we) begin
            chk("store_idle", {31'd0, busy}, 32'd0);
            chk("store_wb_we", {29'd0, wb_we}, 32'd0);
        end else begin
            chk("load_wb_state", {31'd0, busy}, 32'd1);
            chk("load_wb_we", {29'd0, wb_we}, {29'd0, t.e_wbwe});
            @(posedge clk); #1;
            chk("wb_we_pulse", {29'd0, wb_we}, 32'd0);
            chk("load_idle", {31'd0, busy}, 32'd0);
        end
        chk("txn_err", {31'd0, err}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //         we    size   uns   addr          wdata         rd     rdata         dly maddr         be        wdata         wbwe    wbdata
        vt[0]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0,        5'd5,  32'h80AA_BBCC, 2,  32'h0000_0100, 4'b1111, 32'h0,        3'b010, 32'h0000_0080};
        vt[1]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h0000_1234, 5'd0,  32'h0,        1,  32'h0000_0200, 4'b1100, 32'h1234_1234, 3'b000, 32'h0};
        vt[2]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0012, 32'h0,        5'd7,  32'hF00D_0000, 0,  32'h0000_0010, 4'b1111, 32'h0,        3'b101, 32'h0000_F00D};
        vt[3]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0,        5'd0,  32'hDEAD_BEEF, 1,  32'h0000_0040, 4'b1111, 32'h0,        3'b000, 32'h0};
        vt[4]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0301, 32'h0000_00A5, 5'd0,  32'h0,        0,  32'h0000_0300, 4'b0010, 32'hA5A5_A5A5, 3'b000, 32'h0};
        vt[5]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0404, 32'hCAFE_BABE, 5'd0,  32'h0,        3,  32'h0000_0404, 4'b1111, 32'hCAFE_BABE, 3'b000, 32'h0};
        vt[6]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0022, 32'h0,        5'd31, 32'h8001_7FFF, 1,  32'h0000_0020, 4'b1111, 32'h0,        3'b011, 32'h0000_8001};
        vt[7]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0052, 32'h0,        5'd9,  32'h1122_3344, 0,  32'h0000_0050, 4'b1111, 32'h0,        3'b100, 32'h0000_1122};
        vt[8]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0060, 32'h0,        5'd1,  32'h0000_00FE, 0,  32'h0000_0060, 4'b1111, 32'h0,        3'b010, 32'h0000_00FE};
        vt[9]  = '{1'b0, 2'b11, 1'b0, 32'h0000_0070, 32'h0,        5'd2,  32'h1234_5678, 1,  32'h0000_0070, 4'b1111, 32'h0,        3'b001, 32'h1234_5678};
        vt[10] = '{1'b0, 2'b10, 1'b0, 32'h0000_0084, 32'h0,        5'd10, 32'h55AA_00FF, 15, 32'h0000_0084, 4'b1111, 32'h0,        3'b001, 32'h55AA_00FF};
        vt[11] = '{1'b1, 2'b00, 1'b0, 32'h0000_0007, 32'h1234_5678, 5'd0,  32'h0,        2,  32'h0000_0004, 4'b1000, 32'h7878_7878, 3'b000, 32'h0};

        #2 rst = 1'b0;
        #20;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_wb_we", {29'd0, wb_we}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        @(negedge clk) rst = 1'b1;

        for (int i = 0; i < 12; i++) do_txn(vt[i]);

        // Stray ack while idle must be ignored.
        @(negedge clk) mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        chk("idle_ack_busy", {31'd0, busy}, 32'd0);
        chk("idle_ack_wb_we", {29'd0, wb_we}, 32'd0);

        // Timeout: no ack ever.
        v = '{1'b0, 2'b10, 1'b0, 32'h500, 32'h0, 5'd4, 32'h0, 0, 32'h500, 4'b1111, 32'h0, 3'b001, 32'h0};
        drive_req(v);
        @(posedge clk); #1;
        req_valid = 1'b0;
        nreq = 0; nerr = 0; nwb = 0;
        for (int i = 0; i < 40; i++) begin
            if (mem_req) nreq++;
            if (err) nerr++;
            if (wb_we != 3'b000) nwb++;
            @(posedge clk); #1;
        end
        chk("timeout_req_cycles", nreq, 32'd16);
        chk("timeout_err_cycles", nerr, 32'd1);
        chk("timeout_wb_cycles", nwb, 32'd0);
        chk("timeout_ready", {31'd0, req_ready}, 32'd1);

        // Reset in the middle of ACCESS.
        v = '{1'b0, 2'b10, 1'b0, 32'h600, 32'h0, 5'd8, 32'h0, 0, 32'h600, 4'b1111, 32'h0, 3'b001, 32'h0};
        drive_req(v);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("rst_access_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_access_busy", {31'd0, busy}, 32'd0);
        @(negedge clk) rst = 1'b1;
        do_txn('{1'b0, 2'b10, 1'b0, 32'h604, 32'h0, 5'd3, 32'h0BAD_F00D, 1, 32'h604, 4'b1111, 32'h0, 3'b001, 32'h0BAD_F00D});

        // Reset in the WB cycle: writeback must vanish at once.
        v = '{1'b0, 2'b10, 1'b0, 32'h700, 32'h0, 5'd12, 32'h0, 0, 32'h700, 4'b1111, 32'h0, 3'b001, 32'h0};
        drive_req(v);
        @(posedge clk); #1;
        req_valid = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h1111_2222;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        rst     = 1'b0;
        #1;
        chk("rst_wb_we_drop", {29'd0, wb_we}, 32'd0);
        chk("rst_wb_busy", {31'd0, busy}, 32'd0);
        @(negedge clk) rst = 1'b1;

`ifdef LSU_MISALIGN_TRAP_EN
        v = '{1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 5'd6, 32'h0, 0, 32'h100, 4'b1111, 32'h0, 3'b001, 32'h0};
        drive_req(v);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("trap_mem_req", {31'd0, mem_req}, 32'd0);
        chk("trap_busy", {31'd0, busy}, 32'd0);
        chk("trap_err", {31'd0, err}, 32'd1);
        @(posedge clk); #1;
        chk("trap_err_pulse", {31'd0, err}, 32'd0);
        chk("trap_mem_req2", {31'd0, mem_req}, 32'd0);
`else
        do_txn('{1'b0, 2'b01, 1'b0, 32'h83, 32'h0, 5'd6, 32'hABCD_1234, 0, 32'h80, 4'b1111, 32'h0, 3'b011, 32'h0000_ABCD});
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", sbq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
